dcntr_timer: RTL and testbench
==============================

# dcntr_timer

Loadable binary down-counter with terminal-count detection, the counting-down counterpart of the team's loadable up-counter. Software or a controlling FSM loads a start value; the block then decrements on each enabled clock and flags the terminal count with a single-cycle pulse. It serves as the interval/timeout timer beside the up-counter in the datapath.

## Interface
- WIDTH, 4, counter and load-value width in bits (≥2)
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-low: sampled on rising clk edge, 0 = reset
- ld  input  1  parallel load strobe
- d  input  WIDTH  load value, sampled when ld=1
- en  input  1  count enable
- q  output  WIDTH  current count, registered
- tc  output  1  terminal-count pulse, registered, one cycle
- busy  output  1  high while state RUN

## Operation
- State machine, two states: IDLE, RUN.
- Reset (rst=0 at edge): state IDLE, q=0, tc=0, busy=0, reload register rld=0. Reset beats every other input.
- Priority at each edge, not in reset: ld > terminal event > decrement > hold.
- ld=1: q←d, rld←d. If d≠0, state←RUN; if d=0, state←IDLE. tc←0. Applies in any state, so a load mid-run restarts the count.
- RUN, en=1, q>1: q←q−1, tc←0.
- RUN, en=1, q==1 (terminal event): tc←1 and q/state per Configuration.
- RUN, en=0: q holds, tc←0.
- IDLE, ld=0: q holds at its value (0 after a terminal event), tc←0. en is ignored and there is no wrap to all-ones.
- tc is high for exactly one cycle per terminal event. It is never asserted by ld, including ld with d=0.
- busy is a decode of state: busy = (state==RUN).
- Arithmetic is unsigned modulo 2^WIDTH. Underflow cannot occur because q==0 is never decremented.

## Timing
- Load latency 1: ld sampled at edge k gives q=d and busy=1 after edge k.
- With continuous en, a load of N (1 ≤ N ≤ 2^WIDTH−1) gives the terminal event at edge k+N. tc=1 in the cycle following edge k+N.
- Each en=0 cycle during RUN stretches the interval by exactly one cycle.
- ld together with a terminal event (q==1, en=1, ld=1): the load wins. q=d, tc=0, no pulse.
- rst=0 together with ld=1: reset wins. q=0, IDLE.
- Without the macro, tc, q==0 and busy falling are all visible in the same cycle.

## Configuration
- Macro: DCNTR_TIMER_AUTORELOAD_EN.
- Defined (periodic mode): at the terminal event, q←rld, state stays RUN, busy stays 1, tc pulses. Period is rld enabled cycles. q never displays 0 in this mode.
- Undefined (one-shot mode): at the terminal event, q←0, state←IDLE, busy←0, tc pulses. rld is unused and may be optimised away.

## Structure
- Shared package dcntr_pkg holds:
  - state typedef dcntr_state_t with members IDLE, RUN
  - constant DCNTR_WIDTH_DEF = 4
- One sub-module is natural: dcntr_bit, a single-bit down-count cell. It contains:
  - flip-flop with synchronous active-low reset
  - borrow-in/borrow-out logic
  - load mux
- The top instantiates WIDTH dcntr_bit cells in a borrow chain, plus the FSM and the tc register.

## Test plan
- Reset: hold rst=0 for 2 cycles with ld=1, d=9 → q=0, tc=0, busy=0 throughout.
- One-shot run: ld with d=5, then en=1 → q reads 5,4,3,2,1,0 on successive edges. tc=1 only in the cycle q=0, busy falls in that same cycle. Further en pulses leave q=0.
- Enable gating: ld d=4, en pattern 1,0,0,1,1,1 → q 4,3,3,3,2,1,0, with tc on the final cycle.
- Reload mid-run and collision:
  - At q=3, ld d=9 → q=9, no tc.
  - At q=1 with en=1 and ld=1, d=7 → q=7, tc=0.
- Edge values:
  - ld d=0 → q=0, IDLE, no tc.
  - ld d=15 with continuous en → tc exactly 15 cycles later.
- Periodic mode (DCNTR_TIMER_AUTORELOAD_EN defined): ld d=3, en=1 → q 3,2,1,3,2,1,3 with tc on each return to 3. rst=0 mid-sequence → q=0, IDLE.

Source files
------------

// File: rtl/dcntr_pkg.sv
// -----------------------------------------------------------------------------
// dcntr_pkg
//
// Shared definitions for the loadable down-counter timer (dcntr_timer) and
// its single-bit count cell (dcntr_bit).
//
// Contents:
//   dcntr_state_t    - control state of the timer (IDLE, RUN)
//   DCNTR_WIDTH_DEF  - default counter / load-value width in bits
// -----------------------------------------------------------------------------
package dcntr_pkg;

    // Two-state controller: IDLE holds the count, RUN counts down on enable.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } dcntr_state_t;

    // Default width of the count and load value.
    localparam int DCNTR_WIDTH_DEF = 4;

endpackage : dcntr_pkg

// File: rtl/dcntr_bit.sv
// -----------------------------------------------------------------------------
// dcntr_bit
//
// One bit of a ripple-borrow binary down-counter. WIDTH of these are chained
// by dcntr_timer: the borrow into bit 0 is the counter's decrement request,
// and each bit toggles when a borrow arrives, passing the borrow on only when
// it was 0 (0 - 1 needs a borrow from the next bit up).
//
// Update priority at each rising edge:
//   reset (rst=0) > parallel load (ld) > terminal value (term) > toggle (bin)
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   synchronous reset, active-low
//   ld        in   parallel load strobe
//   ld_val    in   this bit of the load value
//   term      in   terminal-count event: force this bit to term_val
//   term_val  in   this bit of the value taken at the terminal event
//   bin       in   borrow in (decrement request reaching this bit)
//   q         out  registered count bit
//   bout      out  borrow out to the next more-significant bit
// -----------------------------------------------------------------------------
module dcntr_bit (
    input  logic clk,
    input  logic rst,
    input  logic ld,
    input  logic ld_val,
    input  logic term,
    input  logic term_val,
    input  logic bin,
    output logic q,
    output logic bout
);

    // NOTE: state is written with non-blocking assignments so every cell in
    // the chain samples the old count before any of them updates.
    always_ff @(posedge clk) begin
        if (!rst) begin
            q <= 1'b0;
        end else if (ld) begin
            q <= ld_val;
        end else if (term) begin
            q <= term_val;
        end else if (bin) begin
            q <= ~q;
        end
    end

    // A bit that is 0 becomes 1 on a decrement and must borrow from above.
    assign bout = bin & ~q;

endmodule : dcntr_bit

// File: rtl/dcntr_timer.sv
// -----------------------------------------------------------------------------
// dcntr_timer
//
// Loadable binary down-counter with terminal-count detection. A load of a
// non-zero value starts a run; each enabled cycle decrements the count, and
// when an enabled cycle finds the count at 1 the terminal event fires: tc
// pulses for one cycle and the count either stops at 0 (one-shot) or restarts
// from the last loaded value (periodic).
//
// Edge priority (outside reset): ld > terminal event > decrement > hold.
// The count is never decremented from 0, so it cannot underflow.
//
// Configuration:
//   DCNTR_TIMER_AUTORELOAD_EN  defined   -> periodic mode (reload from rld)
//                              undefined -> one-shot mode (stop at 0, IDLE)
//
// Parameters:
//   WIDTH   counter / load-value width in bits (>= 2)
//
// Ports:
//   clk   in   rising-edge clock
//   rst   in   synchronous reset, active-low
//   ld    in   parallel load strobe
//   d     in   load value, sampled when ld=1
//   en    in   count enable
//   q     out  current count, registered
//   tc    out  terminal-count pulse, registered, one cycle wide
//   busy  out  high while the timer is in RUN
// -----------------------------------------------------------------------------
module dcntr_timer
    import dcntr_pkg::*;
#(
    parameter int WIDTH = DCNTR_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    input  logic             en,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             busy
);

    dcntr_state_t     state;
    dcntr_state_t     state_nxt;

    logic             run;
    logic             q_one;
    logic             term_ev;
    logic             dec;
    logic [WIDTH-1:0] term_val;
    logic [WIDTH:0]   borrow;
    logic             unused_borrow;

    // -------------------------------------------------------------------------
    // Event decode
    // -------------------------------------------------------------------------
    assign run   = (state == RUN);
    assign q_one = (q == WIDTH'(1));

    // A load always wins, so both events are masked by ld. In RUN the count is
    // never 0, so "not 1" means "greater than 1" and a plain decrement is safe.
    assign term_ev = ~ld & run & en & q_one;
    assign dec     = ~ld & run & en & ~q_one;

    // -------------------------------------------------------------------------
    // Value taken by the count at the terminal event
    // -------------------------------------------------------------------------
`ifdef DCNTR_TIMER_AUTORELOAD_EN
    localparam bit AUTORELOAD = 1'b1;

    logic [WIDTH-1:0] rld;

    // Reload register follows every load so a mid-run load also changes the
    // period. Only non-zero loads can enter RUN, so a reload is never 0.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rld <= '0;
        end else if (ld) begin
            rld <= d;
        end
    end

    assign term_val = rld;
`else
    localparam bit AUTORELOAD = 1'b0;

    assign term_val = '0;
`endif

    // -------------------------------------------------------------------------
    // Count datapath: ripple-borrow chain of single-bit cells
    // -------------------------------------------------------------------------
    assign borrow[0] = dec;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        dcntr_bit u_bit (
            .clk      (clk),
            .rst      (rst),
            .ld       (ld),
            .ld_val   (d[i]),
            .term     (term_ev),
            .term_val (term_val[i]),
            .bin      (borrow[i]),
            .q        (q[i]),
            .bout     (borrow[i+1])
        );
    end

    // Borrow out of the top bit would mean underflow, which dec excludes.
    assign unused_borrow = borrow[WIDTH];

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    // NOTE: the default assignment at the top keeps this block free of
    // inferred latches whatever path the if-chain takes.
    always_comb begin
        state_nxt = state;
        if (ld) begin
            // Loading 0 means there is nothing to count: stay/go IDLE.
            state_nxt = (|d) ? RUN : IDLE;
        end else if (term_ev) begin
            state_nxt = AUTORELOAD ? RUN : IDLE;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    always_comb begin
        busy = (state == RUN);
    end

    // Terminal-count pulse: registered so it lines up with the count (and,
    // in one-shot mode, busy) showing the post-terminal state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tc <= 1'b0;
        end else begin
            tc <= term_ev;
        end
    end

endmodule : dcntr_timer

// File: tb/tb_dcntr_timer.sv
// -----------------------------------------------------------------------------
// tb_dcntr_timer
//
// Self-checking bench for dcntr_timer. Directed scenarios compare against
// literal expected sequences; a randomized run compares every cycle against
// an integer reference model of the timer's rules. Inputs change 1 time unit
// after the rising edge and outputs are sampled at that same point.
// -----------------------------------------------------------------------------
module tb_dcntr_timer;
    import dcntr_pkg::*;

    localparam int W    = DCNTR_WIDTH_DEF;
    localparam int MODV = 1 << W;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         ld  = 1'b0;
    logic [W-1:0] d   = '0;
    logic         en  = 1'b0;
    logic [W-1:0] q;
    logic         tc;
    logic         busy;

    int checks = 0;
    int errors = 0;

    // Reference model: count as a plain integer, run flag, pulse, period.
    int m_q    = 0;
    int m_rld  = 0;
    bit m_run  = 1'b0;
    bit m_tc   = 1'b0;

    always #5 clk = ~clk;

    dcntr_timer #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .ld   (ld),
        .d    (d),
        .en   (en),
        .q    (q),
        .tc   (tc),
        .busy (busy)
    );

    // Apply one edge's worth of the timer rules to the model.
    task automatic model_edge(input bit r, input bit l, input int dv, input bit e);
        if (!r) begin
            m_q = 0; m_rld = 0; m_run = 1'b0; m_tc = 1'b0;
        end else if (l) begin
            m_q = dv; m_rld = dv; m_run = (dv != 0); m_tc = 1'b0;
        end else if (m_run && e && m_q == 1) begin
            m_tc = 1'b1;
`ifdef DCNTR_TIMER_AUTORELOAD_EN
            m_q = m_rld;
`else
            m_q = 0;
            m_run = 1'b0;
`endif
        end else if (m_run && e) begin
            m_q = m_q - 1;
            m_tc = 1'b0;
        end else begin
            m_tc = 1'b0;
        end
    endtask

    // Drive inputs, take one rising edge, advance the model, settle.
    task automatic tick(input bit r, input bit l, input int dv, input bit e);
        rst = r; ld = l; d = W'(dv); en = e;
        @(posedge clk);
        model_edge(r, l, dv % MODV, e);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            tick(1'b0, 1'b1, 9, 1'b1);
            checks++;
            if (q !== '0 || tc !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL reset cycle %0d: got q=%0d tc=%b busy=%b want q=0 tc=0 busy=0",
                         i, q, tc, busy);
            end
        end
    endtask

    task automatic test_load_and_run(input string name, input int load_val,
                                     input int n, input bit en_pat[8],
                                     input int exp_q[8], input bit exp_tc[8],
                                     input bit exp_busy[8]);
        tick(1'b1, 1'b1, load_val, 1'b0);
        checks++;
        if (q !== W'(load_val) || tc !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s load: got q=%0d tc=%b busy=%b want q=%0d tc=0 busy=1",
                     name, q, tc, busy, load_val);
        end
        for (int i = 0; i < n; i++) begin
            tick(1'b1, 1'b0, 0, en_pat[i]);
            checks++;
            if (q !== W'(exp_q[i]) || tc !== exp_tc[i] || busy !== exp_busy[i]) begin
                errors++;
                $display("FAIL %s step %0d: got q=%0d tc=%b busy=%b want q=%0d tc=%b busy=%b",
                         name, i, q, tc, busy, exp_q[i], exp_tc[i], exp_busy[i]);
            end
        end
    endtask

`ifndef DCNTR_TIMER_AUTORELOAD_EN
    task automatic test_one_shot();
        // 5 -> 4,3,2,1,0 then two extra enables leave it parked at 0.
        test_load_and_run("oneshot", 5, 7,
                          '{1, 1, 1, 1, 1, 1, 1, 0},
                          '{4, 3, 2, 1, 0, 0, 0, 0},
                          '{0, 0, 0, 0, 1, 0, 0, 0},
                          '{1, 1, 1, 1, 0, 0, 0, 0});
    endtask

    task automatic test_enable_gating();
        test_load_and_run("gating", 4, 6,
                          '{1, 0, 0, 1, 1, 1, 0, 0},
                          '{3, 3, 3, 2, 1, 0, 0, 0},
                          '{0, 0, 0, 0, 0, 1, 0, 0},
                          '{1, 1, 1, 1, 1, 0, 0, 0});
    endtask
`endif

    task automatic test_reload_collision();
        tick(1'b1, 1'b1, 5, 1'b0);
        tick(1'b1, 1'b0, 0, 1'b1);
        tick(1'b1, 1'b0, 0, 1'b1);
        checks++;
        if (q !== W'(3)) begin
            errors++;
            $display("FAIL midrun_pre: got q=%0d want q=3", q);
        end
        // Load while counting restarts the count.
        tick(1'b1, 1'b1, 9, 1'b1);
        checks++;
        if (q !== W'(9) || tc !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL midrun_load: got q=%0d tc=%b busy=%b want q=9 tc=0 busy=1", q, tc, busy);
        end
        for (int i = 0; i < 8; i++) tick(1'b1, 1'b0, 0, 1'b1);
        checks++;
        if (q !== W'(1) || tc !== 1'b0) begin
            errors++;
            $display("FAIL collide_pre: got q=%0d tc=%b want q=1 tc=0", q, tc);
        end
        // Load coinciding with the terminal event: load wins, no pulse.
        tick(1'b1, 1'b1, 7, 1'b1);
        checks++;
        if (q !== W'(7) || tc !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL collide_load: got q=%0d tc=%b busy=%b want q=7 tc=0 busy=1", q, tc, busy);
        end
        tick(1'b1, 1'b0, 0, 1'b0);
        checks++;
        if (q !== W'(7) || tc !== 1'b0) begin
            errors++;
            $display("FAIL collide_after: got q=%0d tc=%b want q=7 tc=0", q, tc);
        end
    endtask

    task automatic test_edge_values();
        int found;
        tick(1'b1, 1'b1, 0, 1'b1);
        checks++;
        if (q !== '0 || tc !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL load_zero: got q=%0d tc=%b busy=%b want q=0 tc=0 busy=0", q, tc, busy);
        end
        tick(1'b1, 1'b0, 0, 1'b1);
        checks++;
        if (q !== '0 || tc !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_idle: got q=%0d tc=%b busy=%b want q=0 tc=0 busy=0", q, tc, busy);
        end
        // Full-scale load: terminal pulse after exactly MODV-1 enabled edges.
        tick(1'b1, 1'b1, MODV - 1, 1'b1);
        found = 0;
        for (int i = 1; i <= 40; i++) begin
            tick(1'b1, 1'b0, 0, 1'b1);
            if (tc === 1'b1) begin
                found = i;
                break;
            end
        end
        checks++;
        if (found != MODV - 1) begin
            errors++;
            $display("FAIL max_interval: got tc after %0d edges (0 = none in 40) want %0d",
                     found, MODV - 1);
        end
    endtask

`ifdef DCNTR_TIMER_AUTORELOAD_EN
    task automatic test_periodic();
        test_load_and_run("periodic", 3, 6,
                          '{1, 1, 1, 1, 1, 1, 0, 0},
                          '{2, 1, 3, 2, 1, 3, 0, 0},
                          '{0, 0, 1, 0, 0, 1, 0, 0},
                          '{1, 1, 1, 1, 1, 1, 0, 0});
        tick(1'b0, 1'b0, 0, 1'b1);
        checks++;
        if (q !== '0 || tc !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL periodic_reset: got q=%0d tc=%b busy=%b want q=0 tc=0 busy=0", q, tc, busy);
        end
    endtask
`endif

    task automatic test_random();
        bit r, l, e;
        int dv;
        for (int i = 0; i < 600; i++) begin
            r  = ($urandom_range(0, 59) != 0);
            l  = ($urandom_range(0, 9) == 0);
            dv = ($urandom_range(0, 3) == 0) ? $urandom_range(0, MODV - 1) : $urandom_range(0, 4);
            e  = ($urandom_range(0, 3) != 0);
            tick(r, l, dv, e);
            checks++;
            if (q !== W'(m_q) || tc !== m_tc || busy !== m_run) begin
                errors++;
                $display("FAIL random cycle %0d: got q=%0d tc=%b busy=%b want q=%0d tc=%b busy=%b",
                         i, q, tc, busy, m_q, m_tc, m_run);
            end
        end
    endtask

    task automatic test_back_to_back();
        // Consecutive short loads each produce their own pulse.
        for (int k = 1; k <= 3; k++) begin
            tick(1'b1, 1'b1, k, 1'b1);
            for (int i = 1; i < k; i++) tick(1'b1, 1'b0, 0, 1'b1);
            tick(1'b1, 1'b0, 0, 1'b1);
            checks++;
            if (tc !== 1'b1) begin
                errors++;
                $display("FAIL back_to_back load %0d: got tc=%b want tc=1", k, tc);
            end
        end
    endtask

    initial begin
        test_reset();
`ifndef DCNTR_TIMER_AUTORELOAD_EN
        test_one_shot();
        test_enable_gating();
`else
        test_periodic();
`endif
        test_reload_collision();
        test_edge_values();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_dcntr_timer
